// File: rtl/stream_wrr_arbiter.sv
// Packet-granular weighted round-robin merge of STREAM_COUNT valid/ready streams.
// A grant is held for a whole packet, and each owner may send up to W(qos) packets back to back.
module stream_wrr_arbiter #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_i,
  input  logic [STREAM_COUNT-1:0]                   s_last_i,
  input  logic [STREAM_COUNT-1:0]                   s_valid_i,
  output logic [STREAM_COUNT-1:0]                   s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                   m_data_o,
  output logic [T_QOS__WIDTH-1:0]                   m_qos_o,
  output logic [T_ID___WIDTH-1:0]                   m_id_o,
  output logic                                      m_last_o,
  output logic                                      m_valid_o,
  input  logic                                      m_ready_i
);
  localparam int IDW1 = T_ID___WIDTH + 1;

  typedef enum logic {ARB, GRANT} state_t;

  state_t                  state_reg, state_next;
  logic [T_ID___WIDTH-1:0] owner_reg, owner_next;
  logic [T_ID___WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
  logic [T_QOS__WIDTH-1:0] budget_reg, budget_next;
  logic [T_QOS__WIDTH:0]   pkt_cnt_reg, pkt_cnt_next;

  logic [T_DATA_WIDTH-1:0] m_data_reg;
  logic [T_QOS__WIDTH-1:0] m_qos_reg;
  logic [T_ID___WIDTH-1:0] m_id_reg;
  logic                    m_last_reg;
  logic                    m_valid_reg;

  // Candidate order for the search: rr_ptr, rr_ptr+1, ... folded back into 0..STREAM_COUNT-1.
  logic [IDW1-1:0]         cand_sum [STREAM_COUNT];
  logic [T_ID___WIDTH-1:0] cand_idx [STREAM_COUNT];

  logic                    slot_free;
  logic                    accept;
  logic                    found;
  logic [T_ID___WIDTH-1:0] sel;
  logic [T_QOS__WIDTH-1:0] sel_weight;
  logic                    exhausted;
  logic [T_QOS__WIDTH:0]   pkt_cnt_inc;
  logic [T_ID___WIDTH-1:0] owner_inc;

  generate
    for (genvar gi = 0; gi < STREAM_COUNT; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, rr_ptr_reg} + IDW1'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= IDW1'(STREAM_COUNT))
                          ? T_ID___WIDTH'(cand_sum[gi] - IDW1'(STREAM_COUNT))
                          : T_ID___WIDTH'(cand_sum[gi]);
      assign s_ready_o[gi] = (state_reg == GRANT) && (owner_reg == T_ID___WIDTH'(gi)) && slot_free;
    end
  endgenerate

  assign slot_free   = !m_valid_reg || m_ready_i;
  assign accept      = (state_reg == GRANT) && s_valid_i[owner_reg] && slot_free;
  assign exhausted   = pkt_cnt_reg >= {1'b0, budget_reg};
  assign pkt_cnt_inc = pkt_cnt_reg + 1'b1;
  assign owner_inc   = (owner_reg == T_ID___WIDTH'(STREAM_COUNT - 1)) ? '0 : owner_reg + 1'b1;
  assign sel_weight  = (s_qos_i[sel] == '0) ? T_QOS__WIDTH'(1) : s_qos_i[sel];

  // Walk from the far end so the nearest valid candidate to rr_ptr wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = STREAM_COUNT - 1; k >= 0; k--) begin
      if (s_valid_i[cand_idx[k]]) begin
        found = 1'b1;
        sel   = cand_idx[k];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    rr_ptr_next  = rr_ptr_reg;
    budget_next  = budget_reg;
    pkt_cnt_next = pkt_cnt_reg;
    case (state_reg)
      ARB: begin
        if (found) begin
          state_next = GRANT;
          owner_next = sel;
          if ((sel != owner_reg) || exhausted) begin
            budget_next  = sel_weight;
            pkt_cnt_next = '0;
          end
        end
      end
      GRANT: begin
        if (accept && s_last_i[owner_reg]) begin
          state_next   = ARB;
          pkt_cnt_next = pkt_cnt_inc;
          // Keep preferring the owner until its packet budget is used up.
          rr_ptr_next  = (pkt_cnt_inc == {1'b0, budget_reg}) ? owner_inc : owner_reg;
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg   <= ARB;
      owner_reg   <= '0;
      rr_ptr_reg  <= '0;
      budget_reg  <= '0;
      pkt_cnt_reg <= '0;
      m_data_reg  <= '0;
      m_qos_reg   <= '0;
      m_id_reg    <= '0;
      m_last_reg  <= 1'b0;
      m_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      rr_ptr_reg  <= rr_ptr_next;
      budget_reg  <= budget_next;
      pkt_cnt_reg <= pkt_cnt_next;
      if (accept) begin
        m_data_reg  <= s_data_i[owner_reg];
        m_qos_reg   <= s_qos_i[owner_reg];
        m_id_reg    <= owner_reg;
        m_last_reg  <= s_last_i[owner_reg];
        m_valid_reg <= 1'b1;
      end else if (m_ready_i) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  assign m_data_o  = m_data_reg;
  assign m_qos_o   = m_qos_reg;
  assign m_id_o    = m_id_reg;
  assign m_last_o  = m_last_reg;
  assign m_valid_o = m_valid_reg;

endmodule

// File: doc/stream_wrr_arbiter.md
# stream_wrr_arbiter

Packet-granular weighted round-robin arbiter that merges `STREAM_COUNT` valid/ready input streams onto one output stream. Ownership is locked for a whole packet (until the `last` beat), and each stream may send up to a QoS-derived number of consecutive packets before the grant rotates. It sits between the per-source stream producers and the shared downstream sink. It replaces strict-priority QoS selection where low-QoS sources must not be starved.

## Interface
- `T_DATA_WIDTH`, 8, data beat width
- `T_QOS__WIDTH`, 4, QoS field width; also the packet-budget width
- `STREAM_COUNT`, 3, number of input streams (≥2)
- `T_ID___WIDTH`, $clog2(STREAM_COUNT), output stream id width
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-high reset (asserted = 1)
- `s_data_i`  in  [STREAM_COUNT] x T_DATA_WIDTH  input beat data
- `s_qos_i`  in  [STREAM_COUNT] x T_QOS__WIDTH  per-stream QoS / weight
- `s_last_i`  in  STREAM_COUNT  last beat of packet
- `s_valid_i`  in  STREAM_COUNT  input beat valid
- `s_ready_o`  out  STREAM_COUNT  input beat accepted when valid & ready
- `m_data_o`  out  T_DATA_WIDTH  output beat data
- `m_qos_o`  out  T_QOS__WIDTH  QoS of the stream owning the beat
- `m_id_o`  out  T_ID___WIDTH  source stream index
- `m_last_o`  out  1  last beat of packet
- `m_valid_o`  out  1  output beat valid
- `m_ready_i`  in  1  downstream ready

## Operation
- FSM has two states, ARB and GRANT. Registers: `owner`, `rr_ptr`, `budget` (weight latched at grant), `pkt_cnt`, and a one-entry output register.
- Weight `W(i) = (s_qos_i[i] == 0) ? 1 : s_qos_i[i]`, sampled only when a new budget starts. Changes after that are ignored until the next budget.
- ARB: search `rr_ptr, rr_ptr+1, …` (mod STREAM_COUNT) for the first `s_valid_i` set, then go to GRANT with `owner` = that index.
  - If `owner` differs from the previous owner, or the budget is exhausted: `budget <= W(owner)`, `pkt_cnt <= 0`.
  - Otherwise `budget` and `pkt_cnt` are kept.
  - If no valid is set, stay in ARB.
- GRANT:
  - `s_ready_o[owner] = !m_valid_o || m_ready_i`; all other `s_ready_o` bits are 0.
  - An accepted beat loads the output register with data, qos, id = owner, last. `m_valid_o <= 1`.
  - If `m_ready_i` is high and no beat is accepted: `m_valid_o <= 0`.
- Packet end (accepted beat with `s_last_i[owner]`): `pkt_cnt+1`, then go to ARB.
  - If `pkt_cnt+1 == budget`: budget is exhausted, `rr_ptr <= owner+1` (wraps STREAM_COUNT-1 → 0).
  - Else: `rr_ptr <= owner`, so the owner is preferred next and keeps its remaining budget. If the owner is not valid in that ARB cycle, the next valid stream wins and a new budget starts.
- Mid-packet `s_valid_i[owner]` low: the grant holds indefinitely. No timeout, and no interleaving of other streams.
- Beat ordering within a stream is preserved. No beat is dropped or duplicated.

## Timing
- Reset values: `s_ready_o` = 0, `m_valid_o` = 0, `m_data_o` = 0, `m_qos_o` = 0, `m_id_o` = 0, `m_last_o` = 0. Internally: FSM = ARB, `rr_ptr` = 0, `owner` = 0, `pkt_cnt` = 0, `budget` = 0.
- Reset mid-packet discards the output-register beat and any grant state. The first cycle after release is ARB.
- Arbitration takes 1 cycle (ARB) per packet. `s_ready_o` first rises in the cycle after ARB selects.
- A beat accepted at edge N appears on `m_*` after edge N; latency is 1 cycle.
- Full throughput inside a packet when `m_ready_i` = 1. There is a 1-cycle output bubble between packets.
- `s_ready_o` depends combinationally on `m_ready_i` only. `m_*` are registered.
- Output is held stable while `m_valid_o && !m_ready_i`.
- `rr_ptr` and id arithmetic are modulo STREAM_COUNT, including non-power-of-two counts. `pkt_cnt` is T_QOS__WIDTH+1 bits, so a weight of 15 does not overflow.

## Test plan
- **Weighted rotation:** reset, then all three valid continuously. qos = {2, 0, 6}, 3-beat packets, `m_ready_i` = 1. Required `m_id_o` packet sequence: 0,0,1,2,2,2,2,2,2,0,0,1,… Each packet is 3 contiguous beats with `m_last_o` on the 3rd. There is one idle cycle between packets.
- **Backpressure:** `m_ready_i` = 0 for 3 cycles mid-packet of stream 2. `m_data_o`, `m_id_o` = 2 and `m_last_o` stay stable with `m_valid_o` = 1. `s_ready_o` = 0 during the stall. No beat is lost when ready returns.
- **Single requester:** only stream 1 is valid, qos = 0. Consecutive packets all have `m_id_o` = 1. `rr_ptr` advances each packet, and ARB re-finds stream 1 within 1 cycle.
- **Valid gap mid-packet:** stream 0 drops valid for 4 cycles after beat 1 of 3 while streams 1 and 2 are valid. No beats from 1 or 2 appear until stream 0's last beat.
- **Weight change:** change stream 2's qos from 6 to 1 after its 2nd packet. Stream 2 still completes 6 packets in that round, and 1 packet in the next round.
- **Reset mid-packet:** assert `rst_n` = 1 for 1 cycle during beat 2 of a stream 2 packet. Next cycle all outputs are 0. The first subsequent grant goes to the lowest-indexed valid stream from 0.
